// File: rtl/pcf8591_pkg.sv
// Shared encodings and constants for the PCF8591 DAC byte sequencer.
// Holds the sequencer state enum, address nibble, default control byte and FIFO sizing.
package pcf8591_pkg;

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_CTRL = 2'd1,
    ST_DATA = 2'd2
  } seq_state_t;

  localparam logic [3:0] ADDR_NIBBLE       = 4'b1001;
  localparam logic [7:0] DEFAULT_CTRL_BYTE = 8'h40;
  localparam int         FIFO_DEPTH        = 4;
  localparam int         FIFO_PTR_W        = $clog2(FIFO_DEPTH);
  localparam int         FIFO_CNT_W        = FIFO_PTR_W + 1;

  // Write-direction I2C address byte for a given A2..A0 strap.
  function automatic logic [7:0] addr_byte(input logic [2:0] dev_addr);
    return {ADDR_NIBBLE, dev_addr, 1'b0};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// 4-entry byte FIFO for DAC samples; head is read combinationally, push/pop take effect on the edge.
// full is a registered flag so the upstream ready has no combinational path from push or pop.
module sample_fifo
  import pcf8591_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [7:0]            mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic [FIFO_CNT_W-1:0] count_q;
  logic [FIFO_CNT_W-1:0] count_d;
  logic                  full_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are exactly FIFO_PTR_W bits wide, so increments wrap modulo the depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FIFO_CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = full_q;
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/pcf8591_dac_sequencer.sv
// Feeds the I2C transmitter address, control byte, then buffered DAC samples, one byte per readyTransmit.
// writeWord moves only on readyTransmit; an empty buffer at a data slot holds the byte and flags underrun.
module pcf8591_dac_sequencer
  import pcf8591_pkg::*;
#(
  parameter logic [2:0] DEV_ADDR  = 3'b000,
  parameter logic [7:0] CTRL_BYTE = DEFAULT_CTRL_BYTE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_data,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic       readyTransmit,
  output logic [7:0] writeWord,
  output logic       underrun,
  output logic [7:0] underrun_count,
  output logic [1:0] seq_state
);

  seq_state_t            state_q;
  seq_state_t            state_d;
  logic [7:0]            word_q;
  logic [7:0]            word_d;
  logic                  underrun_q;
  logic [7:0]            underrun_cnt_q;
  logic                  data_slot;
  logic                  starve;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_head;
  logic [FIFO_CNT_W-1:0] fifo_count;

  assign sample_ready = !fifo_full;
  assign fifo_push    = sample_valid && sample_ready;
  assign fifo_pop     = data_slot && !fifo_empty;
  assign starve       = data_slot && (fifo_count == '0);

  sample_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (sample_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_ADDR;
      word_q         <= addr_byte(DEV_ADDR);
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      underrun_q <= starve;
      if (starve && (underrun_cnt_q != 8'hFF)) underrun_cnt_q <= underrun_cnt_q + 1'b1;
    end
  end

  // ST_DATA never exits: the transmitter streams samples until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ADDR: if (readyTransmit) state_d = ST_CTRL;
      ST_CTRL: if (readyTransmit) state_d = ST_DATA;
      ST_DATA: state_d = ST_DATA;
      default: state_d = ST_ADDR;
    endcase
  end

  always_comb begin
    data_slot = 1'b0;
    word_d    = word_q;
    case (state_q)
      ST_ADDR: if (readyTransmit) word_d = CTRL_BYTE;
      ST_CTRL, ST_DATA: begin
        data_slot = readyTransmit;
        if (readyTransmit && !fifo_empty) word_d = fifo_head;
      end
      default: word_d = addr_byte(DEV_ADDR);
    endcase
  end

  assign writeWord      = word_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_cnt_q;
  assign seq_state      = state_q;

endmodule

// File: tb/tb_pcf8591_dac_sequencer.sv
// Bench for pcf8591_dac_sequencer: vector table with expected outputs, a sample scoreboard,
// and hand sequences for underrun saturation and asynchronous mid-stream reset.
module tb_pcf8591_dac_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;
  logic       readyTransmit;
  logic [7:0] writeWord;
  logic       underrun;
  logic [7:0] underrun_count;
  logic [1:0] seq_state;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb[$];
  int         st_m;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rt;
    logic [7:0] ww;
    logic [1:0] st;
    logic       ur;
    logic       rdy;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[22];

  pcf8591_dac_sequencer #(.DEV_ADDR(3'b000), .CTRL_BYTE(8'h40)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .readyTransmit  (readyTransmit),
    .writeWord      (writeWord),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .seq_state      (seq_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; the scoreboard supplies the expected byte for each data slot.
  task automatic apply(input logic v, input logic [7:0] d, input logic rt);
    logic       acc;
    logic       have;
    logic [7:0] exp_b;
    sample_valid  = v;
    sample_data   = d;
    readyTransmit = rt;
    have  = 1'b0;
    exp_b = 8'h00;
    chk("sample_ready_pre", 32'(sample_ready), 32'(sb.size() < 4));
    acc = v && (sb.size() < 4);
    if (rt && st_m != 0 && sb.size() > 0) begin
      exp_b = sb.pop_front();
      have  = 1'b1;
    end
    @(posedge clk);
    #1;
    if (acc) sb.push_back(d);
    if (have) chk("sb_byte", 32'(writeWord), 32'(exp_b));
    if (rt && st_m < 2) st_m++;
    sample_valid  = 1'b0;
    readyTransmit = 1'b0;
  endtask

  initial begin
    //            v  d      rt  ww     st    ur  rdy  cnt
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 8'h90, 2'd0, 1'b0, 1'b1, 8'd0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 8'h90, 2'd0, 1'b0, 1'b1, 8'd0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 8'h90, 2'd0, 1'b0, 1'b1, 8'd0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 8'h40, 2'd1, 1'b0, 1'b1, 8'd0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 8'h11, 2'd2, 1'b0, 1'b1, 8'd0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'h22, 2'd2, 1'b0, 1'b1, 8'd0};
    tbl[6]  = '{1'b1, 8'h44, 1'b0, 8'h22, 2'd2, 1'b0, 1'b1, 8'd0};
    tbl[7]  = '{1'b1, 8'h55, 1'b0, 8'h22, 2'd2, 1'b0, 1'b1, 8'd0};
    tbl[8]  = '{1'b1, 8'h66, 1'b0, 8'h22, 2'd2, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 8'h77, 1'b0, 8'h22, 2'd2, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{1'b1, 8'h77, 1'b1, 8'h33, 2'd2, 1'b0, 1'b1, 8'd0};
    tbl[11] = '{1'b1, 8'h77, 1'b0, 8'h33, 2'd2, 1'b0, 1'b0, 8'd0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h44, 2'd2, 1'b0, 1'b1, 8'd0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 8'h55, 2'd2, 1'b0, 1'b1, 8'd0};
    tbl[14] = '{1'b1, 8'hAA, 1'b1, 8'h66, 2'd2, 1'b0, 1'b1, 8'd0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 8'h77, 2'd2, 1'b0, 1'b1, 8'd0};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 8'hAA, 2'd2, 1'b0, 1'b1, 8'd0};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 8'hAA, 2'd2, 1'b1, 1'b1, 8'd1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 8'hAA, 2'd2, 1'b0, 1'b1, 8'd1};
    tbl[19] = '{1'b1, 8'hBB, 1'b1, 8'hAA, 2'd2, 1'b1, 1'b1, 8'd2};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 8'hAA, 2'd2, 1'b0, 1'b1, 8'd2};
    tbl[21] = '{1'b0, 8'h00, 1'b1, 8'hBB, 2'd2, 1'b0, 1'b1, 8'd2};

    reset         = 1'b1;
    sample_data   = 8'h00;
    sample_valid  = 1'b0;
    readyTransmit = 1'b0;
    st_m          = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset_writeWord", 32'(writeWord), 32'h90);
    chk("reset_state", 32'(seq_state), 32'd0);
    chk("reset_ready", 32'(sample_ready), 32'd1);
    chk("reset_underrun", 32'(underrun), 32'd0);
    chk("reset_count", 32'(underrun_count), 32'd0);

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].rt);
      chk($sformatf("vec%0d_writeWord", i), 32'(writeWord), 32'(tbl[i].ww));
      chk($sformatf("vec%0d_state", i), 32'(seq_state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(tbl[i].ur));
      chk($sformatf("vec%0d_ready", i), 32'(sample_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_count", i), 32'(underrun_count), 32'(tbl[i].cnt));
    end

    // Back-to-back starved slots: the count climbs by one per pulse and saturates.
    for (int i = 0; i < 300; i++) begin
      apply(1'b0, 8'h00, 1'b1);
      if (i == 9) chk("underrun_count_12", 32'(underrun_count), 32'd12);
    end
    chk("sat_count", 32'(underrun_count), 32'hFF);
    chk("sat_writeWord_hold", 32'(writeWord), 32'hBB);
    chk("sat_underrun_high", 32'(underrun), 32'd1);
    apply(1'b0, 8'h00, 1'b0);
    chk("underrun_drops", 32'(underrun), 32'd0);
    chk("sat_count_stays", 32'(underrun_count), 32'hFF);

    // Reset mid-cycle with three buffered samples: must clear without a clock edge.
    apply(1'b1, 8'hC1, 1'b0);
    apply(1'b1, 8'hC2, 1'b0);
    apply(1'b1, 8'hC3, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_writeWord", 32'(writeWord), 32'h90);
    chk("async_ready", 32'(sample_ready), 32'd1);
    chk("async_count", 32'(underrun_count), 32'd0);
    chk("async_state", 32'(seq_state), 32'd0);
    sb.delete();
    st_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(1'b0, 8'h00, 1'b1);
    chk("post_reset_ctrl", 32'(writeWord), 32'h40);
    apply(1'b0, 8'h00, 1'b1);
    chk("post_reset_discarded_ww", 32'(writeWord), 32'h40);
    chk("post_reset_discarded_ur", 32'(underrun), 32'd1);
    chk("post_reset_discarded_cnt", 32'(underrun_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pcf8591_dac_sequencer.md
PCF8591_DAC_SEQUENCER -- requirements
Module: pcf8591_dac_sequencer

Interface
REQ-001 The module SHALL have the parameter DEV_ADDR, default 3'b000, meaning the PCF8591 A2..A0 hardware address bits.
REQ-002 The module SHALL have the parameter CTRL_BYTE, default 8'h40, meaning the PCF8591 control byte (analog output enable, channel 0).
REQ-003 The module SHALL have the port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 The module SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have the port sample_data, input, 8 bits: next DAC code from the waveform source.
REQ-006 The module SHALL have the port sample_valid, input, 1 bit: sample_data is valid.
REQ-007 The module SHALL have the port sample_ready, output, 1 bit: the sequencer accepts sample_data this cycle.
REQ-008 The module SHALL have the port readyTransmit, input, 1 bit: one-cycle pulse from the I2C transmitter meaning the last bit of the current writeWord has been taken.
REQ-009 The module SHALL have the port writeWord, output, 8 bits: byte presented to the I2C transmitter.
REQ-010 The module SHALL have the port underrun, output, 1 bit: one-cycle pulse when a data byte is due but no sample is buffered.
REQ-011 The module SHALL have the port underrun_count, output, 8 bits: saturating count of underrun events.
REQ-012 The module SHALL have the port seq_state, output, 2 bits: current sequencer state, for debug.

Function
REQ-013 The sequencer SHALL have the states ST_ADDR=2'd0, ST_CTRL=2'd1 and ST_DATA=2'd2; 2'd3 is unused and SHALL recover to ST_ADDR.
REQ-014 In ST_ADDR, writeWord SHALL equal {4'b1001, DEV_ADDR, 1'b0} (write address).
REQ-015 In ST_ADDR, a readyTransmit pulse SHALL move the state to ST_CTRL and SHALL load writeWord=CTRL_BYTE on the same clock edge.
REQ-016 In ST_CTRL, a readyTransmit pulse SHALL move the state to ST_DATA and SHALL load the next data byte per REQ-018/019.
REQ-017 ST_DATA SHALL be terminal (the transmitter streams indefinitely); only reset leaves it.
REQ-018 On readyTransmit in ST_CTRL or ST_DATA with the FIFO non-empty, the sequencer SHALL pop the FIFO head into writeWord on that edge.
REQ-019 On readyTransmit in ST_CTRL or ST_DATA with the FIFO empty, writeWord SHALL hold its previous value, underrun SHALL pulse high on the next cycle, and underrun_count SHALL increment, saturating at 8'hFF.
REQ-020 writeWord SHALL change only on the edge sampling readyTransmit=1, and is therefore stable at least 15 clk before the transmitter loads bit 7.
REQ-021 The sample buffer SHALL be a 4-entry FIFO with 3-bit occupancy.
REQ-022 sample_ready SHALL be a registered function of occupancy: sample_ready=1 iff occupancy<4.
REQ-023 A push SHALL occur when sample_valid and sample_ready are both 1.
REQ-024 On a simultaneous push and pop, occupancy SHALL be unchanged and the popped entry SHALL be the older head.
REQ-025 A push while the FIFO is empty SHALL NOT bypass to writeWord in the same cycle; a pop on an empty FIFO counts as an underrun even if a push occurs that cycle.
REQ-026 The FIFO read and write pointers SHALL wrap modulo 4.
REQ-027 readyTransmit pulses arriving back-to-back on consecutive cycles SHALL each be processed as a separate byte advance.

Reset
REQ-028 On reset, the state SHALL return to ST_ADDR, writeWord={4'b1001,DEV_ADDR,1'b0}, FIFO occupancy and pointers to 0, sample_ready to 1, underrun to 0 and underrun_count to 0.
REQ-029 Reset asserted mid-stream SHALL discard buffered samples immediately (asynchronously), without waiting for a byte boundary.

Structure
REQ-030 The shared package pcf8591_pkg SHALL hold the state encodings, the address nibble 4'b1001, the default CTRL_BYTE and FIFO depth 4.
REQ-031 The FIFO SHALL be a separate sub-module named sample_fifo (8-bit data, depth 4, push/pop/full/empty/count); the sequencer FSM, byte mux and underrun counter SHALL be in the top module.

Verification
REQ-032 Reset release, DEV_ADDR=3'b000 -> writeWord=8'h90, seq_state=0; first readyTransmit -> writeWord=8'h40 and seq_state=1 after that edge.
REQ-033 Preload samples 8'h11, 8'h22, 8'h33, then issue 2 more readyTransmit pulses -> writeWord=8'h11, then 8'h22; seq_state=2; no underrun.
REQ-034 Push 4 samples with no pops -> sample_ready=0 after the 4th push; a 5th sample held valid is not accepted until one readyTransmit pop, then it is accepted.
REQ-035 Empty FIFO in ST_DATA with writeWord=8'h22, then readyTransmit -> writeWord stays 8'h22, underrun pulses for 1 cycle, underrun_count=1; 300 underruns -> count=8'hFF.
REQ-036 Simultaneous push of 8'hAA and pop with occupancy 2 -> occupancy stays 2 and the popped byte is the older head.
REQ-037 Reset asserted in ST_DATA with occupancy 3 -> next outputs are writeWord=8'h90, sample_ready=1, underrun_count=0.
